parity_frame_ctrl: RTL and testbench

Shared serial parity checker with a two-channel round-robin scheduler. Two serial sources request the checker, and the block grants one at a time. It clocks in a fixed-length data frame followed by one parity bit, accumulates running parity in a single internal register, and reports pass/fail with the channel ID. It sits in front of the serial parity datapath so that several bit-serial links can share one checker.

---
 rtl/parity_frame_ctrl.sv | 141 ++++++++++++++
 tb/tb_parity_frame_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/parity_frame_ctrl.sv
// Shared serial parity checker fronted by a two-channel round-robin arbiter.
// Latency: grant one cycle after request; done/err/chan DATA_BITS+2 cycles after grant.
// Backpressure: none; the owning channel must hold req for the frame or the frame aborts.
module parity_frame_ctrl #(
    parameter int DATA_BITS = 8,
    parameter bit ODD       = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic req0,
    input  logic req1,
    input  logic x0,
    input  logic x1,
    output logic gnt0,
    output logic gnt1,
    output logic busy,
    output logic done,
    output logic err,
    output logic chan,
    output logic abort
);

    localparam int CW = (DATA_BITS < 2) ? 1 : $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        PAR  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state, state_nxt;
    logic            owner, owner_nxt;
    logic [CW-1:0]   cnt, cnt_nxt;
    logic            par, par_nxt;
    logic            last, last_nxt;
    logic            err_nxt, chan_nxt, done_nxt, abort_nxt;
    logic            gnt0_nxt, gnt1_nxt, busy_nxt;
    logic            sel_req, sel_x;

    // Next-state, datapath and registered-output decode; every output is a flop fed from here.
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        cnt_nxt   = cnt;
        par_nxt   = par;
        last_nxt  = last;
        err_nxt   = err;
        chan_nxt  = chan;
        done_nxt  = 1'b0;
        abort_nxt = 1'b0;
        sel_req   = owner ? req1 : req0;
        sel_x     = owner ? x1 : x0;

        case (state)
            IDLE: begin
                if (req0 || req1) begin
                    // On a tie the channel not served most recently wins.
                    owner_nxt = (req0 && req1) ? ~last : req1;
                    state_nxt = DATA;
                    cnt_nxt   = '0;
                    par_nxt   = 1'b0;
                end
            end
            DATA: begin
                if (!sel_req) begin
                    state_nxt = IDLE;
                    abort_nxt = 1'b1;
                    chan_nxt  = owner;
                    last_nxt  = owner;
                end else begin
                    par_nxt = par ^ sel_x;
                    cnt_nxt = cnt + CW'(1);
                    if (cnt == LAST_CNT) begin
                        state_nxt = PAR;
                    end
                end
            end
            PAR: begin
                if (!sel_req) begin
                    state_nxt = IDLE;
                    abort_nxt = 1'b1;
                    chan_nxt  = owner;
                    last_nxt  = owner;
                end else begin
                    // par now holds the fail flag: nonzero when total ones disagree with the mode.
                    par_nxt   = par ^ sel_x ^ ODD;
                    state_nxt = DONE;
                    last_nxt  = owner;
                end
            end
            DONE: begin
                state_nxt = IDLE;
                done_nxt  = 1'b1;
                err_nxt   = par;
                chan_nxt  = owner;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Grant is held through DATA, PAR and DONE so it drops on the same edge done rises.
        gnt0_nxt = (state_nxt != IDLE) && !owner_nxt;
        gnt1_nxt = (state_nxt != IDLE) && owner_nxt;
        busy_nxt = (state_nxt == DATA) || (state_nxt == PAR);
    end

    // State, datapath and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            owner <= 1'b0;
            cnt   <= '0;
            par   <= 1'b0;
            last  <= 1'b1;
            gnt0  <= 1'b0;
            gnt1  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
            chan  <= 1'b0;
            abort <= 1'b0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            cnt   <= cnt_nxt;
            par   <= par_nxt;
            last  <= last_nxt;
            gnt0  <= gnt0_nxt;
            gnt1  <= gnt1_nxt;
            busy  <= busy_nxt;
            done  <= done_nxt;
            err   <= err_nxt;
            chan  <= chan_nxt;
            abort <= abort_nxt;
        end
    end

endmodule

// File: tb/tb_parity_frame_ctrl.sv
// Bench for parity_frame_ctrl: three instances (even/8, odd/8, even/1) driven frame by frame.
// Expected results come from frame-level arithmetic and a round-robin pointer kept per instance.
// All sampling and driving happens on the falling clock edge.
module tb_parity_frame_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] req0 = '0, req1 = '0, x0 = '0, x1 = '0;
    logic [2:0] gnt0, gnt1, busy, done, err, chan, abort;

    int   tests = 0;
    int   fails = 0;
    logic last_m [3];
    logic exp_err [3];
    logic exp_chan [3];

    always #5 clk = ~clk;

    parity_frame_ctrl #(.DATA_BITS(8), .ODD(1'b0)) u_even (
        .clk(clk), .rst(rst), .req0(req0[0]), .req1(req1[0]), .x0(x0[0]), .x1(x1[0]),
        .gnt0(gnt0[0]), .gnt1(gnt1[0]), .busy(busy[0]), .done(done[0]), .err(err[0]),
        .chan(chan[0]), .abort(abort[0])
    );
    parity_frame_ctrl #(.DATA_BITS(8), .ODD(1'b1)) u_odd (
        .clk(clk), .rst(rst), .req0(req0[1]), .req1(req1[1]), .x0(x0[1]), .x1(x1[1]),
        .gnt0(gnt0[1]), .gnt1(gnt1[1]), .busy(busy[1]), .done(done[1]), .err(err[1]),
        .chan(chan[1]), .abort(abort[1])
    );
    parity_frame_ctrl #(.DATA_BITS(1), .ODD(1'b0)) u_one (
        .clk(clk), .rst(rst), .req0(req0[2]), .req1(req1[2]), .x0(x0[2]), .x1(x1[2]),
        .gnt0(gnt0[2]), .gnt1(gnt1[2]), .busy(busy[2]), .done(done[2]), .err(err[2]),
        .chan(chan[2]), .abort(abort[2])
    );

    function automatic int nb_of(input int d);
        return (d == 2) ? 1 : 8;
    endfunction

    function automatic logic odd_of(input int d);
        return (d == 1);
    endfunction

    function automatic logic gnt_of(input int d, input int ch);
        return (ch != 0) ? gnt1[d] : gnt0[d];
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic set_req(input int d, input int ch, input logic v);
        if (ch != 0) req1[d] = v;
        else         req0[d] = v;
    endtask

    task automatic set_x(input int d, input int ch, input logic v);
        if (ch != 0) x1[d] = v;
        else         x0[d] = v;
    endtask

    task automatic model_reset();
        for (int d = 0; d < 3; d++) begin
            last_m[d]   = 1'b1;
            exp_err[d]  = 1'b0;
            exp_chan[d] = 1'b0;
        end
    endtask

    task automatic chk_all_zero(input int d, input string tag);
        chk({tag, "_gnt0"}, gnt0[d], 0);
        chk({tag, "_gnt1"}, gnt1[d], 0);
        chk({tag, "_busy"}, busy[d], 0);
        chk({tag, "_done"}, done[d], 0);
        chk({tag, "_err"}, err[d], 0);
        chk({tag, "_chan"}, chan[d], 0);
        chk({tag, "_abort"}, abort[d], 0);
    endtask

    // Requests channel ch on instance d, expects the grant one edge later, then shifts
    // the frame in. drop_at = k drops req at the edge that would sample bit k
    // (k == nb means the parity edge); negative means a complete frame.
    // Returns on the falling edge where done (or abort) is visible.
    task automatic run_frame(input int d, input int ch, input logic [7:0] data,
                             input logic p, input int drop_at, input bit keep);
        int   nb;
        int   w;
        int   ones;
        bit   got;
        logic exp_e;
        nb  = nb_of(d);
        got = 1'b0;
        w   = 0;
        set_req(d, ch, 1'b1);
        while (!got && w < 40) begin
            @(negedge clk);
            w++;
            if (gnt_of(d, ch)) got = 1'b1;
        end
        chk("grant_latency", w, 1);
        if (!got) begin
            set_req(d, ch, 1'b0);
            return;
        end
        chk("grant_one_hot", gnt_of(d, 1 - ch), 0);
        chk("busy_on_grant", busy[d], 1);
        for (int k = 0; k <= nb; k++) begin
            set_x(d, ch, (k == nb) ? p : data[k]);
            if (drop_at == k) set_req(d, ch, 1'b0);
            @(negedge clk);
            if (drop_at == k) begin
                chk("abort_pulse", abort[d], 1);
                chk("abort_no_done", done[d], 0);
                chk("abort_err_held", err[d], exp_err[d]);
                chk("abort_chan", chan[d], ch);
                chk("abort_gnt_drop", gnt_of(d, ch), 0);
                chk("abort_busy", busy[d], 0);
                last_m[d]   = ch[0];
                exp_chan[d] = ch[0];
                return;
            end
            chk("no_early_done", done[d], 0);
            chk("gnt_held", gnt_of(d, ch), 1);
        end
        // Now in the DONE cycle: grant still high, busy low.
        chk("busy_in_done", busy[d], 0);
        @(negedge clk);
        ones = p;
        for (int k = 0; k < nb; k++) ones += data[k];
        exp_e = ((ones % 2) == 1) != odd_of(d);
        chk("done_pulse", done[d], 1);
        chk("err_result", err[d], exp_e);
        chk("chan_result", chan[d], ch);
        chk("gnt_drop_at_done", gnt_of(d, ch), 0);
        chk("no_abort", abort[d], 0);
        exp_err[d]  = exp_e;
        exp_chan[d] = ch[0];
        last_m[d]   = ch[0];
        if (!keep) set_req(d, ch, 1'b0);
    endtask

    initial begin
        int   d;
        int   r;
        int   win;
        int   drop;
        model_reset();

        // Reset state on every instance.
        repeat (2) @(negedge clk);
        for (int i = 0; i < 3; i++) chk_all_zero(i, "reset");
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 3; i++) chk_all_zero(i, "post_reset_idle");

        // Tie right after reset: ch0, then ch1, then ch0 again with both still requesting.
        req1[0] = 1'b1;
        run_frame(0, 0, 8'($urandom), 1'($urandom), -1, 1'b1);
        run_frame(0, 1, 8'($urandom), 1'($urandom), -1, 1'b1);
        run_frame(0, 0, 8'($urandom), 1'($urandom), -1, 1'b0);
        req1[0] = 1'b0;

        // Even parity, ch0 only: 1,0,1,1,0,1,1,0 with p=1 passes, p=0 fails.
        run_frame(0, 0, 8'h6D, 1'b1, -1, 1'b0);
        chk("even_pass_err", exp_err[0], 0);
        run_frame(0, 0, 8'h6D, 1'b0, -1, 1'b0);
        chk("even_fail_err", err[0], 1);

        // Odd parity: 0,1,1,1,0,1,1,0 with p=0 passes, p=1 fails.
        run_frame(1, 0, 8'h6E, 1'b0, -1, 1'b0);
        chk("odd_pass_err", err[1], 0);
        run_frame(1, 0, 8'h6E, 1'b1, -1, 1'b0);
        chk("odd_fail_err", err[1], 1);

        // ch1 wins the tie (ch0 served last), drops after 3 bits; pending ch0 follows.
        req0[0] = 1'b1;
        run_frame(0, 1, 8'($urandom), 1'b0, 3, 1'b0);
        run_frame(0, 0, 8'($urandom), 1'($urandom), -1, 1'b0);

        // Reset in the middle of DATA clears everything at once.
        req0[0] = 1'b1;
        @(negedge clk);
        chk("pre_rst_gnt0", gnt0[0], 1);
        repeat (3) begin
            x0[0] = 1'($urandom);
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        chk_all_zero(0, "async_reset");
        model_reset();
        req1[0] = 1'b1;
        @(negedge clk);
        chk_all_zero(0, "held_reset");
        rst = 1'b0;
        run_frame(0, 0, 8'($urandom), 1'($urandom), -1, 1'b0);
        req1[0] = 1'b0;

        // Single data bit: 1 + p=1 passes under even parity.
        run_frame(2, 0, 8'h01, 1'b1, -1, 1'b0);
        chk("one_bit_err", err[2], 0);

        // Randomized frames: random instance, request pattern, data, parity and aborts.
        for (int i = 0; i < 30; i++) begin
            d   = $urandom_range(0, 2);
            r   = $urandom_range(1, 3);
            win = (r == 3) ? int'(!last_m[d]) : ((r == 2) ? 1 : 0);
            drop = ($urandom_range(0, 3) == 0) ? $urandom_range(0, nb_of(d)) : -1;
            req0[d] = r[0];
            req1[d] = r[1];
            run_frame(d, win, 8'($urandom), 1'($urandom), drop, 1'b0);
            req0[d] = 1'b0;
            req1[d] = 1'b0;
            @(negedge clk);
            chk("rand_done_one_cycle", done[d], 0);
            chk("rand_abort_one_cycle", abort[d], 0);
            chk("rand_idle_gnt", gnt0[d] | gnt1[d], 0);
            chk("rand_err_hold", err[d], exp_err[d]);
            chk("rand_chan_hold", chan[d], exp_chan[d]);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
